// File: rtl/shift_add_mult4_pkg.sv
// Shared constants for the shift-add multiplier.
// State encoding and step limits.
package shift_add_mult4_pkg;

   localparam int WIDTH = 4;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_CALC = 2'b01;
   localparam logic [1:0] S_DONE = 2'b10;

   localparam logic [1:0] LAST_STEP = 2'd3;

endpackage

// File: rtl/shift_add_mult4_if.sv
// Start/busy/done handshake and operand/product bus
// for the shift-add multiplier.
interface shift_add_mult4_if;
   import shift_add_mult4_pkg::*;

   logic                 start;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 busy;
   logic                 done;
   logic [2*WIDTH-1:0]   product;

   modport master (
      output start, a, b,
      input  busy, done, product
   );

   modport slave (
      input  start, a, b,
      output busy, done, product
   );

endinterface

// File: rtl/shift_add_mult4_adder4.sv
// 4-bit ripple-carry adder, 5-bit sum including carry-out.
// Shared by every add-shift step of the multiplier.
module adder4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [4:0] sum
);

   always_comb begin
      logic c;
      sum = '0;
      c   = cin;
      for (int i = 0; i < 4; i++) begin
         sum[i] = a[i] ^ b[i] ^ c;
         c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
      sum[4] = c;
   end

endmodule

// File: rtl/shift_add_mult4.sv
// Sequential 4x4 unsigned multiplier: one shared adder,
// four add-shift steps, start/busy/done handshake.
module shift_add_mult4
   import shift_add_mult4_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   shift_add_mult4_if.slave  bus
);

   logic [1:0]         state;
   logic [WIDTH-1:0]   m;
   logic [WIDTH-1:0]   hi;
   logic [WIDTH-1:0]   lo;
   logic [1:0]         cnt;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   addend;
   logic [WIDTH:0]     s;

   assign addend = lo[0] ? m : '0;

   adder4 u_add (
      .a   (hi),
      .b   (addend),
      .cin (1'b0),
      .sum (s)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         m     <= '0;
         hi    <= '0;
         lo    <= '0;
         cnt   <= '0;
         prod  <= '0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (bus.start) begin
                  m     <= bus.a;
                  lo    <= bus.b;
                  hi    <= '0;
                  cnt   <= '0;
                  state <= S_CALC;
               end
            end
            S_CALC: begin
               // carry-out lands in hi[3]; s[0] shifts into lo
               hi  <= s[WIDTH:1];
               lo  <= {s[0], lo[WIDTH-1:1]};
               cnt <= cnt + 2'd1;
               if (cnt == LAST_STEP) begin
                  prod  <= {s[WIDTH:1], s[0], lo[WIDTH-1:1]};
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy    = (state != S_IDLE);
   assign bus.done    = (state == S_DONE);
   assign bus.product = prod;

endmodule

// File: tb/tb_shift_add_mult4.sv
// Directed bench for the shift-add multiplier:
// latency, handshake, reset abort and full operand sweep.
module tb_shift_add_mult4;

   logic clk;
   logic reset;
   int   nchecks;
   int   nerrors;
   int   dbl_done;
   logic prev_done;

   shift_add_mult4_if bus ();

   shift_add_mult4 dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!reset && prev_done && bus.done) dbl_done++;
      prev_done = bus.done;
   end

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      nchecks++;
      if (obs !== exp) begin
         nerrors++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Waits for done (bounded); returns cycles since accept.
   task automatic wait_done(output int lat, output int pulses);
      lat    = 0;
      pulses = 0;
      while (lat < 12) begin
         @(negedge clk);
         lat++;
         if (bus.done) begin
            pulses++;
            break;
         end
      end
   endtask

   task automatic do_mult(input string tag,
                          input logic [3:0] x,
                          input logic [3:0] y,
                          input logic [7:0] exp);
      int lat, pulses;
      @(negedge clk);
      bus.a     = x;
      bus.b     = y;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      bus.a = 4'h0;
      bus.b = 4'h0;
      @(negedge clk);
      check({tag, "_busy1"}, bus.busy, 1);
      lat = 1;
      pulses = 0;
      if (!bus.done) begin
         int l2;
         wait_done(l2, pulses);
         lat += l2;
      end
      check({tag, "_lat"}, lat, 5);
      check({tag, "_prod"}, bus.product, exp);
      @(negedge clk);
      check({tag, "_busy0"}, bus.busy, 0);
      check({tag, "_done0"}, bus.done, 0);
      check({tag, "_hold"}, bus.product, exp);
   endtask

   initial begin
      int lat, pulses, cyc;
      nchecks   = 0;
      nerrors   = 0;
      dbl_done  = 0;
      prev_done = 1'b0;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.a     = 4'h0;
      bus.b     = 4'h0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_prod", bus.product, 0);

      do_mult("m3x5", 4'd3, 4'd5, 8'h0F);
      do_mult("mFxF", 4'hF, 4'hF, 8'hE1);
      do_mult("mFx1", 4'hF, 4'h1, 8'h0F);
      do_mult("m1xF", 4'h1, 4'hF, 8'h0F);
      do_mult("m0x9", 4'h0, 4'h9, 8'h00);
      do_mult("mFxF2", 4'hF, 4'hF, 8'hE1);
      do_mult("m9x0", 4'h9, 4'h0, 8'h00);

      // start raised while busy must be ignored
      @(negedge clk);
      bus.a     = 4'd2;
      bus.b     = 4'd3;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.a = 4'd7;
      bus.b = 4'd7;
      pulses = 0;
      lat    = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (bus.done) begin
            pulses++;
            if (lat == 0) lat = i;
         end
         if (i == 4) bus.start = 1'b0;
      end
      check("ign_lat", lat, 5);
      check("ign_prod", bus.product, 8'h06);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done) pulses++;
      end
      check("ign_extra", pulses, 0);
      check("ign_busy", bus.busy, 0);
      do_mult("m7x7", 4'd7, 4'd7, 8'h31);

      // reset in the second CALC cycle aborts
      @(negedge clk);
      bus.a     = 4'hF;
      bus.b     = 4'hF;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort_busy", bus.busy, 0);
      check("abort_done", bus.done, 0);
      check("abort_prod", bus.product, 0);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done) pulses++;
      end
      check("abort_nodone", pulses, 0);
      do_mult("m6x7", 4'd6, 4'd7, 8'h2A);

      // full sweep, start held high
      @(negedge clk);
      bus.start = 1'b1;
      for (int idx = 0; idx < 256; idx++) begin
         bus.a = idx[7:4];
         bus.b = idx[3:0];
         check("sw_idle", bus.busy, 0);
         wait_done(lat, pulses);
         check("sw_lat", lat, 5);
         check("sw_prod", bus.product, 8'(idx[7:4] * idx[3:0]));
         @(negedge clk);
         cyc = lat + 1;
         check("sw_period", cyc, 6);
         check("sw_done_off", bus.done, 0);
      end
      bus.start = 1'b0;
      repeat (8) @(negedge clk);
      check("dbl_done", dbl_done, 0);

      $display("Simulation finished: %0d checks, %0d errors",
               nchecks, nerrors);
      $finish;
   end

endmodule
